compare_serial: RTL and testbench

//  Multi-cycle comparator for wide operands. Compares a and b DIGIT bits per

---
 rtl/compare_pkg.sv | 19 +
 rtl/compare.sv | 19 +
 rtl/compare_serial.sv | 138 +++++++++++++
 tb/tb_compare_serial.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/compare_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// compare_pkg : shared FSM encoding and digit-count helper for compare_serial
// Rev 1.0
// ---------------------------------------------------------------------------
package compare_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    function automatic int ndig(input int size, input int digit);
        return size / digit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/compare.sv
`default_nettype none
// ---------------------------------------------------------------------------
// compare : single-cycle unsigned magnitude compare of two SIZE-bit values
// Rev 1.0
// ---------------------------------------------------------------------------
module compare #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            gt,
    output logic            eq
);

    assign gt = (a > b);
    assign eq = (a == b);

endmodule
`default_nettype wire

// File: rtl/compare_serial.sv
`default_nettype none
// ---------------------------------------------------------------------------
// compare_serial : digit-serial MSB-first comparator with early exit.
// Optional SIGNED_CMP_EN adds is_signed (two's-complement via MSB bias).
// Rev 1.0
// ---------------------------------------------------------------------------
module compare_serial
    import compare_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int DIGIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
`ifdef SIGNED_CMP_EN
    input  logic            is_signed,
`endif
    output logic            busy,
    output logic            done,
    output logic            gt,
    output logic            eq,
    output logic            lt
);

    localparam int NDIG  = ndig(SIZE, DIGIT);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (((SIZE % DIGIT) != 0) || (NDIG < 1)) begin : g_bad_params
            $error("compare_serial: SIZE must be a non-zero multiple of DIGIT");
        end
    endgenerate

    cmp_state_t             state;
    cmp_state_t             state_nxt;
    logic [SIZE-1:0]        sh_a;
    logic [SIZE-1:0]        sh_b;
    logic [IDX_W-1:0]       idx;
    logic [SIZE-1:0]        load_a;
    logic [SIZE-1:0]        load_b;
    logic                   dig_gt;
    logic                   dig_eq;

`ifdef SIGNED_CMP_EN
    localparam logic [SIZE-1:0] SIGN_MASK = SIZE'(1) << (SIZE - 1);

    // Flipping both sign bits maps two's-complement order onto unsigned order.
    assign load_a = is_signed ? (a ^ SIGN_MASK) : a;
    assign load_b = is_signed ? (b ^ SIGN_MASK) : b;
`else
    assign load_a = a;
    assign load_b = b;
`endif

    compare #(.SIZE(DIGIT)) u_digit_cmp (
        .a  (sh_a[SIZE-1 -: DIGIT]),
        .b  (sh_b[SIZE-1 -: DIGIT]),
        .gt (dig_gt),
        .eq (dig_eq)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CMP;
                end
            end
            CMP: begin
                busy = 1'b1;
                if (!dig_eq || (idx == '0)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_a <= '0;
            sh_b <= '0;
            idx  <= '0;
            gt   <= 1'b0;
            eq   <= 1'b0;
            lt   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a <= load_a;
                        sh_b <= load_b;
                        idx  <= IDX_W'(NDIG - 1);
                        gt   <= 1'b0;
                        eq   <= 1'b0;
                        lt   <= 1'b0;
                    end
                end
                CMP: begin
                    if (!dig_eq) begin
                        gt <= dig_gt;
                        eq <= 1'b0;
                        lt <= ~dig_gt;
                    end else if (idx == '0) begin
                        gt <= 1'b0;
                        eq <= 1'b1;
                        lt <= 1'b0;
                    end else begin
                        sh_a <= sh_a << DIGIT;
                        sh_b <= sh_b << DIGIT;
                        idx  <= idx - IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_compare_serial.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_compare_serial : directed + random checks of compare_serial against a
// cycle-level reference model.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_compare_serial;

    localparam int SIZE  = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = SIZE / DIGIT;
`ifdef SIGNED_CMP_EN
    localparam bit HAS_SIGNED = 1'b1;
`else
    localparam bit HAS_SIGNED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        sgn = 1'b0;
    logic        busy, done, gt, eq, lt;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, gt8, eq8, lt8;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    compare_serial #(.SIZE(SIZE), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef SIGNED_CMP_EN
        .is_signed (sgn),
`endif
        .busy      (busy),
        .done      (done),
        .gt        (gt),
        .eq        (eq),
        .lt        (lt)
    );

    compare_serial #(.SIZE(8), .DIGIT(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .start     (start8),
        .a         (a8),
        .b         (b8),
`ifdef SIGNED_CMP_EN
        .is_signed (1'b0),
`endif
        .busy      (busy8),
        .done      (done8),
        .gt        (gt8),
        .eq        (eq8),
        .lt        (lt8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Digits examined = position of the most significant differing digit.
    function automatic int calc_k(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] d;
        d = x ^ y;
        if (d == '0) return NDIG;
        for (int i = 15; i >= 0; i--) begin
            if (d[i]) return NDIG - (i / DIGIT);
        end
        return NDIG;
    endfunction

    function automatic logic [2:0] ref_res(input logic [15:0] x, input logic [15:0] y, input bit s);
        if (s) begin
            if ($signed(x) > $signed(y)) return 3'b100;
            if ($signed(x) < $signed(y)) return 3'b001;
            return 3'b010;
        end
        if (x > y) return 3'b100;
        if (x < y) return 3'b001;
        return 3'b010;
    endfunction

    // Reference model: age counts cycles since acceptance (1 = first compare cycle).
    bit         m_active = 1'b0;
    int         m_age    = 0;
    int         m_k      = 0;
    logic [2:0] m_p      = '0;
    logic [2:0] m_out    = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
            m_age    = 0;
            m_out    = '0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_age    = 1;
                m_k      = calc_k(a, b);
                m_p      = ref_res(a, b, HAS_SIGNED && sgn);
                m_out    = '0;
            end
        end else begin
            m_age++;
            if (m_age == m_k + 1) m_out = m_p;
            if (m_age == m_k + 2) m_active = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("per_cycle {busy,done,gt,eq,lt}", {27'd0, busy, done, gt, eq, lt},
                  {27'd0, m_active && (m_age <= m_k), m_active && (m_age == m_k + 1), m_out});
        end
    end

    task automatic wait_done(input int first, output int lat);
        lat = -1;
        for (int n = first; n < first + 12; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_cmp(input logic [15:0] x, input logic [15:0] y, input bit s,
                           input int lit_k, input logic [2:0] lit_res, input string nm);
        int lat;
        @(posedge clk); #2;
        a = x; b = y; sgn = s; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check({nm, "_model_k"}, m_k, lit_k);
        check({nm, "_model_res"}, {29'd0, m_p}, {29'd0, lit_res});
        wait_done(1, lat);
        check({nm, "_latency"}, lat, lit_k + 1);
        check({nm, "_result"}, {29'd0, gt, eq, lt}, {29'd0, lit_res});
    endtask

    initial begin
        int lat;
        int ndone;
        logic [7:0] x8, y8;
        logic [2:0] e8;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        check("reset_state8", {27'd0, busy8, done8, gt8, eq8, lt8}, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        chk_en = 1'b1;

        run_cmp(16'h1234, 16'h1234, 1'b0, 4, 3'b010, "t1_equal");
        run_cmp(16'h9000, 16'h1FFF, 1'b0, 1, 3'b100, "t2_early_gt");
        run_cmp(16'h1233, 16'h1234, 1'b0, 4, 3'b001, "t2_late_lt");
        run_cmp(16'h0000, 16'hFFFF, 1'b0, 1, 3'b001, "t2_zero_max");
        run_cmp(16'hABCD, 16'hAB0D, 1'b0, 3, 3'b100, "t2_digit3_gt");
        run_cmp(16'hFFFF, 16'hFFFF, 1'b0, 4, 3'b010, "t2_max_eq");
`ifdef SIGNED_CMP_EN
        run_cmp(16'h8000, 16'h0001, 1'b1, 1, 3'b001, "t3_signed_lt");
        run_cmp(16'h8000, 16'h0001, 1'b0, 1, 3'b100, "t3_unsigned_gt");
        run_cmp(16'hFFFF, 16'h0001, 1'b1, 1, 3'b001, "t3_neg1_lt");
        run_cmp(16'hFFFE, 16'hFFFF, 1'b1, 4, 3'b001, "t3_neg2_lt");
`endif

        // Start held through cycles 1-3 of an in-flight compare must be ignored.
        @(posedge clk); #2;
        a = 16'h1234; b = 16'h1234; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        a = 16'hFFFF; b = 16'h0000;
        @(posedge clk); #2;
        @(posedge clk); #2;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(4, lat);
        check("t4_ignored_latency", lat, 5);
        check("t4_ignored_result", {29'd0, gt, eq, lt}, 32'b010);
        run_cmp(16'hFFFF, 16'h0000, 1'b0, 1, 3'b100, "t4_back_to_back");

        // Reset in cycle 2 of an equal-operand compare aborts with no done.
        @(posedge clk); #2;
        a = 16'h1234; b = 16'h1234; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("t5_reset_abort", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t5_no_done_after_reset", ndone, 0);
        run_cmp(16'h1234, 16'h1234, 1'b0, 4, 3'b010, "t5_after_reset");

        // NDIG == 1 instance: done two cycles after start.
        for (int i = 0; i < 10000; i++) begin
            if (i == 0) begin
                x8 = 8'hFF; y8 = 8'h00;
            end else if (i == 1) begin
                x8 = 8'h5A; y8 = 8'h5A;
            end else begin
                x8 = 8'($urandom);
                y8 = (i % 16 == 0) ? x8 : 8'($urandom);
            end
            e8 = (x8 > y8) ? 3'b100 : ((x8 == y8) ? 3'b010 : 3'b001);
            @(posedge clk); #2;
            a8 = x8; b8 = y8; start8 = 1'b1;
            @(posedge clk); #2;
            start8 = 1'b0;
            @(negedge clk);
            check("t6_cycle1", {27'd0, busy8, done8, gt8, eq8, lt8}, 32'b10000);
            @(negedge clk);
            check("t6_cycle2", {27'd0, busy8, done8, gt8, eq8, lt8}, {27'd0, 2'b01, e8});
            if (i == 0) check("t6_ff_vs_00", {29'd0, gt8, eq8, lt8}, 32'b100);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
